// File: rtl/ssd_scan_if.sv
// Request/acknowledge and display-pin bundle between a value producer and the
// seven-segment scan sequencer.
interface ssd_scan_if;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic        loadAck;
    logic        blankLz;
    logic [7:0]  anode;
    logic [7:0]  cathode;
    logic [1:0]  digitIdx;

    modport master (
        output enable, value, load, blankLz,
        input  loadAck, anode, cathode, digitIdx
    );

    modport slave (
        input  enable, value, load, blankLz,
        output loadAck, anode, cathode, digitIdx
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Four-digit seven-segment scanner: blank gap before each digit, registered
// pin drive, and a tear-free value load that only lands on frame boundaries.
module ssd_scan_ctrl #(
    parameter int BLANK_CYCLES = 1000,
    parameter int DRIVE_CYCLES = 100000,
    parameter int TMR_W        = 17
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    ssd_scan_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    localparam logic [TMR_W-1:0] BlankLast = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [TMR_W-1:0] DriveLast = TMR_W'(DRIVE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      value_q, value_d;
    logic             loadAck_q, loadAck_d;
    logic [7:0]       anode_q, anode_d;
    logic [7:0]       cathode_q, cathode_d;

    logic             boundary;
    logic             accept;
    logic             digitBlanked;
    logic [3:0]       nibble;

    // Active-low segment pattern {a,b,c,d,e,f,g,dp}; the decimal point stays dark.
    function automatic logic [7:0] encode(input logic [3:0] n);
        case (n)
            4'h0:    encode = 8'b00000011;
            4'h1:    encode = 8'b10011111;
            4'h2:    encode = 8'b00100101;
            4'h3:    encode = 8'b00001101;
            4'h4:    encode = 8'b10011001;
            4'h5:    encode = 8'b01001001;
            4'h6:    encode = 8'b01000001;
            4'h7:    encode = 8'b00011111;
            4'h8:    encode = 8'b00000001;
            4'h9:    encode = 8'b00001001;
            4'hA:    encode = 8'b00010001;
            4'hB:    encode = 8'b11000001;
            4'hC:    encode = 8'b01100011;
            4'hD:    encode = 8'b10000101;
            4'hE:    encode = 8'b01100001;
            default: encode = 8'b01110001;
        endcase
    endfunction

    always_comb begin
        nibble       = value_q[{idx_q, 2'b00} +: 4];
        digitBlanked = 1'b0;
        case (idx_q)
            2'd1:    digitBlanked = bus.blankLz && (value_q[15:4] == 12'd0);
            2'd2:    digitBlanked = bus.blankLz && (value_q[15:8] == 8'd0);
            2'd3:    digitBlanked = bus.blankLz && (value_q[15:12] == 4'd0);
            default: digitBlanked = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        anode_d   = 8'hFF;
        cathode_d = 8'hFF;

        boundary  = (state_q == DRIVE) && (idx_q == 2'd3) && (timer_q == DriveLast);
        accept    = bus.load && ((state_q == IDLE) || boundary);
        value_d   = accept ? bus.value : value_q;
        loadAck_d = accept;

        if (!bus.enable) begin
            state_d = IDLE;
            timer_d = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    timer_d = '0;
                    idx_d   = 2'd0;
                end
                BLANK: begin
                    if (timer_q == BlankLast) begin
                        state_d = DRIVE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                DRIVE: begin
                    // idx wraps 3 -> 0 naturally, which is exactly the frame boundary
                    if (timer_q == DriveLast) begin
                        state_d = BLANK;
                        timer_d = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                    idx_d   = 2'd0;
                end
            endcase
        end

        if ((state_q == DRIVE) && !digitBlanked) begin
            anode_d[idx_q] = 1'b0;
            cathode_d      = encode(nibble);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= 2'd0;
            value_q   <= 16'd0;
            loadAck_q <= 1'b0;
            anode_q   <= 8'hFF;
            cathode_q <= 8'hFF;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            value_q   <= value_d;
            loadAck_q <= loadAck_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign bus.anode    = anode_q;
    assign bus.cathode  = cathode_q;
    assign bus.loadAck  = loadAck_q;
    assign bus.digitIdx = idx_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: a frame-position reference model predicts every
// pin each cycle while directed and random scenarios drive the handshake.
module tb_ssd_scan_ctrl;

    localparam int B     = 2;
    localparam int D     = 4;
    localparam int P     = B + D;
    localparam int FRAME = 4 * P;
    localparam logic [7:0] SEG [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001};
    localparam logic [18:0] DARK = {8'hFF, 8'hFF, 3'b000};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ssd_scan_if bus ();

    ssd_scan_ctrl #(
        .BLANK_CYCLES(B),
        .DRIVE_CYCLES(D),
        .TMR_W(17)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: whether a scan is running and the cycle position inside the frame.
    logic        mRun;
    int          mPos;
    logic [15:0] mVal;
    logic [7:0]  expAnode, expCathode;
    logic [1:0]  expIdx;
    logic        expAck;

    logic        nRun;
    int          nPos, nDig;
    logic [15:0] nVal, nShift;
    logic [7:0]  nA, nC;
    logic        nAck;

    always_comb begin
        nA     = 8'hFF;
        nC     = 8'hFF;
        nDig   = mPos / P;
        nShift = mVal >> (4 * nDig);
        if (mRun && (mPos % P) >= B && !(bus.blankLz && nDig > 0 && nShift == 16'd0)) begin
            nA = ~(8'd1 << nDig);
            nC = SEG[nShift[3:0]];
        end
        nAck = bus.load && (!mRun || mPos == FRAME - 1);
        nVal = nAck ? bus.value : mVal;
        nRun = bus.enable;
        nPos = (bus.enable && mRun) ? (mPos + 1) % FRAME : 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mRun       <= 1'b0;
            mPos       <= 0;
            mVal       <= 16'd0;
            expAnode   <= 8'hFF;
            expCathode <= 8'hFF;
            expIdx     <= 2'd0;
            expAck     <= 1'b0;
        end else begin
            mRun       <= nRun;
            mPos       <= nPos;
            mVal       <= nVal;
            expAnode   <= nA;
            expCathode <= nC;
            expIdx     <= 2'(nPos / P);
            expAck     <= nAck;
        end
    end

    wire [18:0] obs      = {bus.anode, bus.cathode, bus.digitIdx, bus.loadAck};
    wire [18:0] modelExp = {expAnode, expCathode, expIdx, expAck};

    task automatic test_reset();
        bit found = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== DARK) begin
            errors++;
            $display("[TB] FAIL reset_initial got %h expected %h", obs, DARK);
        end
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL reset_model got %h expected %h", obs, modelExp);
            end
            if (expIdx == 2'd2 && expAnode == 8'hFB) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL reset_reach_digit2 got timeout expected drive of digit 2");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== DARK) begin
            errors++;
            $display("[TB] FAIL reset_async got %h expected %h", obs, DARK);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL reset_restart_model got %h expected %h", obs, modelExp);
            end
            checks++;
            if (bus.anode !== ((i >= 4) ? 8'hFE : 8'hFF)) begin
                errors++;
                $display("[TB] FAIL reset_restart_anode cycle %0d got %h expected %h",
                         i, bus.anode, (i >= 4) ? 8'hFE : 8'hFF);
            end
        end
    endtask

    task automatic test_scan();
        bit         acked = 0;
        logic [7:0] cath [4];
        logic [7:0] want [4];
        logic [7:0] prevAn = 8'hFF;
        int         firstLow [$];
        int         frameLen;
        want = '{8'b01110001, 8'b00010001, 8'b00100101, 8'b10011111};
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 16'h12AF;
        for (int i = 0; i < 10 && !acked; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL scan_load_model got %h expected %h", obs, modelExp);
            end
            if (bus.loadAck) begin
                acked    = 1;
                bus.load = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            errors++;
            $display("[TB] FAIL scan_idle_ack got timeout expected Load_ack");
        end
        for (int d = 0; d < 4; d++) cath[d] = 8'hFF;
        bus.enable = 1'b1;
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL scan_model got %h expected %h", obs, modelExp);
            end
            for (int d = 0; d < 4; d++) if (bus.anode[d] === 1'b0) cath[d] = bus.cathode;
            if (prevAn[0] === 1'b1 && bus.anode[0] === 1'b0) firstLow.push_back(c);
            prevAn = bus.anode;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cath[d] !== want[d]) begin
                errors++;
                $display("[TB] FAIL scan_digit%0d got %b expected %b", d, cath[d], want[d]);
            end
        end
        frameLen = (firstLow.size() >= 2) ? firstLow[1] - firstLow[0] : -1;
        checks++;
        if (frameLen != FRAME) begin
            errors++;
            $display("[TB] FAIL scan_frame_len got %0d expected %0d", frameLen, FRAME);
        end
    endtask

    task automatic test_load_midframe();
        bit         acked = 0;
        logic [7:0] cath [4];
        logic [7:0] want [4];
        want = '{8'b00100101, 8'b10011001, 8'b00000011, 8'b00000011};
        repeat ($urandom_range(3, 15)) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL midload_pre_model got %h expected %h", obs, modelExp);
            end
        end
        bus.load  = 1'b1;
        bus.value = 16'h0042;
        for (int i = 0; i < 2 * FRAME && !acked; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL midload_wait_model got %h expected %h", obs, modelExp);
            end
            if (bus.loadAck) begin
                acked    = 1;
                bus.load = 1'b0;
            end
        end
        checks++;
        if (!acked) begin
            errors++;
            $display("[TB] FAIL midload_ack got timeout expected Load_ack");
        end
        for (int d = 0; d < 4; d++) cath[d] = 8'hFF;
        for (int c = 0; c < FRAME + 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL midload_frame_model got %h expected %h", obs, modelExp);
            end
            for (int d = 0; d < 4; d++) if (bus.anode[d] === 1'b0) cath[d] = bus.cathode;
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cath[d] !== want[d]) begin
                errors++;
                $display("[TB] FAIL midload_digit%0d got %b expected %b", d, cath[d], want[d]);
            end
        end
    endtask

    task automatic test_blank_lz();
        logic [15:0] vals  [5];
        logic [3:0]  masks [3];
        logic [3:0]  seen;
        bit          acked;
        vals  = '{16'h0000, 16'h0105, 16'h0005, 16'($urandom), 16'($urandom) >> 8};
        masks = '{4'b0001, 4'b0111, 4'b0001};
        bus.blankLz = 1'b1;
        for (int t = 0; t < 5; t++) begin
            acked     = 0;
            bus.load  = 1'b1;
            bus.value = vals[t];
            for (int i = 0; i < 2 * FRAME && !acked; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== modelExp) begin
                    errors++;
                    $display("[TB] FAIL blanklz_wait_model got %h expected %h", obs, modelExp);
                end
                if (bus.loadAck) begin
                    acked    = 1;
                    bus.load = 1'b0;
                end
            end
            checks++;
            if (!acked) begin
                errors++;
                $display("[TB] FAIL blanklz_ack value %h got timeout expected Load_ack", vals[t]);
            end
            seen = 4'b0000;
            for (int c = 0; c < FRAME + 2; c++) begin
                @(negedge clk);
                checks++;
                if (obs !== modelExp) begin
                    errors++;
                    $display("[TB] FAIL blanklz_model value %h got %h expected %h",
                             vals[t], obs, modelExp);
                end
                seen = seen | ~bus.anode[3:0];
            end
            if (t < 3) begin
                checks++;
                if (seen !== masks[t]) begin
                    errors++;
                    $display("[TB] FAIL blanklz_digits value %h got %b expected %b",
                             vals[t], seen, masks[t]);
                end
            end
        end
        bus.blankLz = 1'b0;
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL endrop_pre_model got %h expected %h", obs, modelExp);
            end
            if (mRun && mPos / P == 1 && mPos % P < B) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL endrop_reach_blank1 got timeout expected BLANK of digit 1");
        end
        bus.enable = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.anode, bus.digitIdx} !== {8'hFF, 2'd0}) begin
                errors++;
                $display("[TB] FAIL endrop_dark got an=%h idx=%0d expected an=ff idx=0",
                         bus.anode, bus.digitIdx);
            end
        end
        bus.enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL endrop_restart_model got %h expected %h", obs, modelExp);
            end
            checks++;
            if (bus.anode !== ((i >= 4) ? 8'hFE : 8'hFF)) begin
                errors++;
                $display("[TB] FAIL endrop_restart_anode cycle %0d got %h expected %h",
                         i, bus.anode, (i >= 4) ? 8'hFE : 8'hFF);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ackAt [$];
        int gap;
        bus.load  = 1'b1;
        bus.value = 16'($urandom);
        for (int c = 0; c < 3 * FRAME && ackAt.size() < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL b2b_model got %h expected %h", obs, modelExp);
            end
            if (bus.loadAck) ackAt.push_back(c);
        end
        bus.load = 1'b0;
        gap = (ackAt.size() >= 2) ? ackAt[1] - ackAt[0] : -1;
        checks++;
        if (gap != FRAME) begin
            errors++;
            $display("[TB] FAIL b2b_gap got %0d expected %0d", gap, FRAME);
        end
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);
        bus.load  = 1'b1;
        bus.value = 16'($urandom);
        @(negedge clk);
        checks++;
        if (bus.loadAck !== 1'b1 || obs !== modelExp) begin
            errors++;
            $display("[TB] FAIL idle_ack got %h expected %h with ack=1", obs, modelExp);
        end
        bus.load = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.loadAck !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_ack_pulse got %b expected 0", bus.loadAck);
        end
    endtask

    task automatic test_random();
        bus.enable = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== modelExp) begin
                errors++;
                $display("[TB] FAIL random_model cycle %0d got %h expected %h", c, obs, modelExp);
            end
            if ($urandom_range(0, 59) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(0, 99) == 0) bus.blankLz = ~bus.blankLz;
            if (bus.load && bus.loadAck) begin
                bus.load = 1'b0;
            end else if (!bus.load && $urandom_range(0, 19) == 0) begin
                bus.load  = 1'b1;
                bus.value = 16'($urandom) >> (4 * $urandom_range(0, 4));
            end
        end
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.value   = 16'd0;
        bus.load    = 1'b0;
        bus.blankLz = 1'b0;
        test_reset();
        test_scan();
        test_load_midframe();
        test_blank_lz();
        test_enable_drop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
